// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between instruction fetch and load/store.
// MEM has fixed priority; a starvation counter forces a fetch grant after STARVE_MAX losses.
module ram_arbiter #(
  parameter int RAM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [63:0]       if_addr,
  output logic              if_rsp_valid,
  output logic [63:0]       if_rsp_data,
  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic [63:0]       mem_addr,
  input  logic              mem_we,
  input  logic [7:0]        mem_wstrb,
  input  logic [63:0]       mem_wdata,
  output logic              mem_rsp_valid,
  output logic [63:0]       mem_rsp_data,
  output logic              ram_en,
  output logic [7:0]        ram_wbe,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  input  logic [63:0]       ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP_IF,
    S_RESP_MEM
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_next_starve;
  logic       r_mem_we;
  logic       w_next_mem_we;
  logic       w_idle;
  logic       w_mem_pri;
  logic       w_grant_if;
  logic       w_grant_mem;
  logic       w_unused;

  // Only the word-index bits of each address reach the RAM; the rest wrap away.
  assign w_unused = ^{if_addr[63:RAM_AW+3], if_addr[2:0],
                      mem_addr[63:RAM_AW+3], mem_addr[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 4'd0;
      r_mem_we     <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_starve_cnt <= w_next_starve;
      r_mem_we     <= w_next_mem_we;
    end
  end

  always_comb begin
    w_idle        = (r_state == S_IDLE) && !rst;
    w_mem_pri     = mem_req_valid && (r_starve_cnt < STARVE_LIM);
    w_grant_mem   = w_idle && mem_req_valid && (w_mem_pri || !if_req_valid);
    w_grant_if    = w_idle && if_req_valid && !w_mem_pri;

    w_next_state  = r_state;
    w_next_starve = r_starve_cnt;
    w_next_mem_we = r_mem_we;
    if_req_ready  = w_grant_if;
    mem_req_ready = w_grant_mem;
    if_rsp_valid  = 1'b0;
    if_rsp_data   = 64'd0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 64'd0;
    ram_en        = 1'b0;
    ram_wbe       = 8'd0;
    ram_addr      = '0;
    ram_wdata     = 64'd0;

    case (r_state)
      S_IDLE: begin
        // Fetch either got its turn or is not waiting, so its loss streak ends.
        if (!if_req_valid || w_grant_if) begin
          w_next_starve = 4'd0;
        end else if (w_grant_mem && (r_starve_cnt < STARVE_LIM)) begin
          w_next_starve = r_starve_cnt + 4'd1;
        end

        if (w_grant_if) begin
          w_next_state = S_RESP_IF;
          ram_en       = 1'b1;
          ram_addr     = if_addr[RAM_AW+2:3];
        end else if (w_grant_mem) begin
          w_next_state  = S_RESP_MEM;
          w_next_mem_we = mem_we;
          ram_en        = 1'b1;
          ram_addr      = mem_addr[RAM_AW+2:3];
          if (mem_we) begin
            ram_wbe   = mem_wstrb;
            ram_wdata = mem_wdata;
          end
        end
      end

      S_RESP_IF: begin
        w_next_state = S_IDLE;
        if (!rst) begin
          if_rsp_valid = 1'b1;
          if_rsp_data  = ram_rdata;
        end
      end

      S_RESP_MEM: begin
        w_next_state = S_IDLE;
        if (!rst) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = r_mem_we ? 64'd0 : ram_rdata;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scoreboard bench for ram_arbiter with a behavioural RAM model.
// Stimulus pushes expected handshakes/responses; a monitor pops and compares them.
module tb_ram_arbiter;

  localparam int RAM_AW     = 12;
  localparam int STARVE_MAX = 4;
  localparam int RAM_WORDS  = 1 << RAM_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid;
  logic              if_req_ready;
  logic [63:0]       if_addr;
  logic              if_rsp_valid;
  logic [63:0]       if_rsp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [63:0]       mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wstrb;
  logic [63:0]       mem_wdata;
  logic              mem_rsp_valid;
  logic [63:0]       mem_rsp_data;
  logic              ram_en;
  logic [7:0]        ram_wbe;
  logic [RAM_AW-1:0] ram_addr;
  logic [63:0]       ram_wdata;
  logic [63:0]       ram_rdata;

  typedef struct {
    bit                isMem;
    logic [RAM_AW-1:0] addr;
    logic [7:0]        wbe;
    logic [63:0]       wdata;
  } hs_t;

  typedef struct {
    bit          isMem;
    logic [63:0] data;
  } rsp_t;

  hs_t         expHs[$];
  rsp_t        expRsp[$];
  int          nCompared   = 0;
  int          nMismatched = 0;
  int          hsSeen      = 0;
  bit          doPreload;
  logic [63:0] ramModel [0:RAM_WORDS-1];

  ram_arbiter #(.RAM_AW(RAM_AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ram_en(ram_en), .ram_wbe(ram_wbe), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] initWord(input int i);
    if (i == 5) return 64'h1122334455667788;
    if (i == 8) return 64'h0;
    return {32'hC0DE0000 + 32'(i), 32'(i)};
  endfunction

  // RAM macro model; read data during a write or an idle cycle is deliberately junk.
  always @(posedge clk) begin
    if (doPreload) begin
      for (int i = 0; i < RAM_WORDS; i++) ramModel[i] <= initWord(i);
    end
    if (ram_en) begin
      if (ram_wbe != 8'd0) begin
        ram_rdata <= 64'hBAD0BAD0BAD0BAD0;
        for (int b = 0; b < 8; b++)
          if (ram_wbe[b]) ramModel[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= ramModel[ram_addr];
      end
    end else begin
      ram_rdata <= 64'hDEADBEEFDEADBEEF;
    end
  end

  function automatic logic [255:0] allOut();
    return 256'({if_req_ready, if_rsp_valid, if_rsp_data, mem_req_ready, mem_rsp_valid,
                 mem_rsp_data, ram_en, ram_wbe, ram_addr, ram_wdata});
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expectAccess(input bit isMem, input logic [RAM_AW-1:0] addr,
                              input logic [7:0] wbe, input logic [63:0] wdata,
                              input logic [63:0] rspData, input bit expectRsp);
    hs_t  h;
    rsp_t r;
    h.isMem = isMem; h.addr = addr; h.wbe = wbe; h.wdata = wdata;
    expHs.push_back(h);
    if (expectRsp) begin
      r.isMem = isMem; r.data = rspData;
      expRsp.push_back(r);
    end
  endtask

  // Contention traffic: fetch reads word 2, MEM loads word 3.
  task automatic expectGrant(input bit isMem);
    if (isMem) expectAccess(1'b1, 12'd3, 8'h0, 64'h0, 64'hC0DE000300000003, 1'b1);
    else       expectAccess(1'b0, 12'd2, 8'h0, 64'h0, 64'hC0DE000200000002, 1'b1);
  endtask

  // Issues one request from a negedge and returns at the negedge after its handshake.
  task automatic applyStimulus(input bit isMem, input logic [63:0] addr, input bit we,
                               input logic [7:0] wstrb, input logic [63:0] wdata,
                               input logic [RAM_AW-1:0] expAddr, input logic [63:0] expData,
                               input bit expectRsp);
    bit done = 1'b0;
    expectAccess(isMem, expAddr, (isMem && we) ? wstrb : 8'h0,
                 (isMem && we) ? wdata : 64'h0, expData, expectRsp);
    if (isMem) begin
      mem_req_valid = 1'b1; mem_addr = addr; mem_we = we;
      mem_wstrb = wstrb; mem_wdata = wdata;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    for (int c = 0; c < 20; c++) begin
      #4;
      done = isMem ? mem_req_ready : if_req_ready;
      @(negedge clk);
      if (done) break;
    end
    checkOutput("hsTimeout", 256'(done), 256'd1);
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
    if_addr       = 64'hFFFF_FFFF_FFFF_FFF8;
    mem_addr      = 64'hFFFF_FFFF_FFFF_FFF8;
    mem_we        = 1'b1;
    mem_wstrb     = 8'hFF;
    mem_wdata     = 64'h5555555555555555;
  endtask

  task automatic runBoth(input int n);
    int target = hsSeen + n;
    if_addr = 64'h10; mem_addr = 64'h18; mem_we = 1'b0; mem_wstrb = 8'h0;
    if_req_valid = 1'b1; mem_req_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (hsSeen >= target) break;
    end
    checkOutput("bothTimeout", 256'(hsSeen >= target), 256'd1);
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
  endtask

  // Monitor: checks every handshake and response against the scoreboard queues.
  initial begin
    hs_t  h;
    rsp_t r;
    bit   ifHs, memHs;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        ifHs  = if_req_valid && if_req_ready;
        memHs = mem_req_valid && mem_req_ready;
        checkOutput("readyOneHot", 256'(if_req_ready & mem_req_ready), 256'd0);
        if (ifHs || memHs) begin
          hsSeen++;
          if (expHs.size() == 0) begin
            nCompared++; nMismatched++;
            $display("[TB] FAIL unexpectedHs: got port mem=%0d, expected none at %0t", memHs, $time);
          end else begin
            h = expHs.pop_front();
            checkOutput("hsPort",   256'(memHs),     256'(h.isMem));
            checkOutput("ramEn",    256'(ram_en),    256'd1);
            checkOutput("ramAddr",  256'(ram_addr),  256'(h.addr));
            checkOutput("ramWbe",   256'(ram_wbe),   256'(h.wbe));
            checkOutput("ramWdata", 256'(ram_wdata), 256'(h.wdata));
          end
        end else begin
          checkOutput("ramIdle", 256'({ram_en, ram_wbe, ram_addr, ram_wdata}), 256'd0);
        end
        if (if_rsp_valid || mem_rsp_valid) begin
          checkOutput("rspOneHot", 256'(if_rsp_valid & mem_rsp_valid), 256'd0);
          checkOutput("noReadyInResp", 256'({if_req_ready, mem_req_ready}), 256'd0);
          if (expRsp.size() == 0) begin
            nCompared++; nMismatched++;
            $display("[TB] FAIL unexpectedRsp: got if=%0d mem=%0d, expected none at %0t",
                     if_rsp_valid, mem_rsp_valid, $time);
          end else begin
            r = expRsp.pop_front();
            checkOutput("rspPort", 256'(mem_rsp_valid), 256'(r.isMem));
            checkOutput("rspData", 256'(r.isMem ? mem_rsp_data : if_rsp_data), 256'(r.data));
            checkOutput("rspOtherZero", 256'(r.isMem ? if_rsp_data : mem_rsp_data), 256'd0);
          end
        end else begin
          checkOutput("rspIdleZero", 256'({if_rsp_data, mem_rsp_data}), 256'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; doPreload = 1'b1;
    if_req_valid = 1'b1; mem_req_valid = 1'b1;
    if_addr = 64'h28; mem_addr = 64'h40; mem_we = 1'b1;
    mem_wstrb = 8'hFF; mem_wdata = 64'h1234;
    repeat (2) @(negedge clk);
    #4 checkOutput("resetOutputs", allOut(), 256'd0);
    @(negedge clk);
    rst = 1'b0; doPreload = 1'b0;
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    #4 checkOutput("idleOutputs", allOut(), 256'd0);
    @(negedge clk);

    $display("[TB] fetch read of word 5");
    applyStimulus(1'b0, 64'h28, 1'b0, 8'h0, 64'h0, 12'd5, 64'h1122334455667788, 1'b1);

    $display("[TB] byte-masked store then load of word 8");
    applyStimulus(1'b1, 64'h40, 1'b1, 8'h0F, 64'hAAAAAAAABBBBBBBB, 12'd8, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h40, 1'b0, 8'h0, 64'h0, 12'd8, 64'h00000000BBBBBBBB, 1'b1);

    $display("[TB] wrap-around fetch");
    applyStimulus(1'b0, 64'h8008, 1'b0, 8'h0, 64'h0, 12'd1, 64'hC0DE000100000001, 1'b1);

    $display("[TB] contention");
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < STARVE_MAX; m++) expectGrant(1'b1);
      expectGrant(1'b0);
    end
    runBoth(10);
    @(negedge clk);

    $display("[TB] reset after MEM load handshake");
    applyStimulus(1'b1, 64'h18, 1'b0, 8'h0, 64'h0, 12'd3, 64'h0, 1'b0);
    rst = 1'b1;
    #4;
    checkOutput("rspSquashed", 256'(mem_rsp_valid), 256'd0);
    checkOutput("rstAllZero", allOut(), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    #4 checkOutput("postRstZero", allOut(), 256'd0);
    @(negedge clk);
    expectGrant(1'b0);
    if_addr = 64'h10; if_req_valid = 1'b1;
    #4 checkOutput("postRstIdleReady", 256'(if_req_ready), 256'd1);
    @(negedge clk);
    if_req_valid = 1'b0;
    @(negedge clk);

    $display("[TB] starve counter clear");
    for (int m = 0; m < 3; m++) expectGrant(1'b1);
    runBoth(3);
    repeat (2) @(negedge clk);
    for (int m = 0; m < 4; m++) expectGrant(1'b1);
    expectGrant(1'b0);
    runBoth(5);

    repeat (4) @(negedge clk);
    checkOutput("hsLeft",  256'(expHs.size()),  256'd0);
    checkOutput("rspLeft", 256'(expRsp.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the SoC's single-port instruction/data RAM between the instruction-fetch port and the load/store (MEM) port of the RV64 core. Each port uses a valid/ready request channel and a one-cycle response pulse, with one transaction outstanding at a time. The arbiter sits between the core and the RAM macro inside `soc`. MEM has fixed priority, and an anti-starvation counter guarantees fetch progress.

## Interface
Parameters:
- `RAM_AW`, 12: RAM word-address width (2^RAM_AW 64-bit words).
- `STARVE_MAX`, 4: consecutive lost arbitrations after which fetch wins; range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_addr`  in  64  fetch byte address.
- `if_rsp_valid`  out  1  fetch read data valid, one-cycle pulse.
- `if_rsp_data`  out  64  fetch read data; 0 when `if_rsp_valid`=0.
- `mem_req_valid`  in  1  load/store request.
- `mem_req_ready`  out  1  load/store request accepted this cycle.
- `mem_addr`  in  64  load/store byte address.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_wstrb`  in  8  store byte enables; bit i covers byte i.
- `mem_wdata`  in  64  store data.
- `mem_rsp_valid`  out  1  load data or store acknowledge, one-cycle pulse.
- `mem_rsp_data`  out  64  load data; 0 for stores and when `mem_rsp_valid`=0.
- `ram_en`  out  1  RAM access strobe.
- `ram_wbe`  out  8  RAM byte write enables; 0 for reads.
- `ram_addr`  out  RAM_AW  RAM word address.
- `ram_wdata`  out  64  RAM write data.
- `ram_rdata`  in  64  RAM read data, valid the cycle after `ram_en`.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - RESP_IF: fetch response cycle.
  - RESP_MEM: MEM response cycle.
- Grant in IDLE (combinational):
  - MEM wins if `mem_req_valid` and `starve_cnt` < STARVE_MAX.
  - Otherwise fetch wins if `if_req_valid`.
  - Otherwise MEM wins if `mem_req_valid`.
- `*_req_ready` = 1 only in IDLE, and only for the granted port. Both are 0 in RESP_*.
- Handshake fires when valid and ready are both 1. In that cycle:
  - `ram_en`=1.
  - `ram_addr` = addr[RAM_AW+2:3].
  - For a MEM store: `ram_wbe` = `mem_wstrb` and `ram_wdata` = `mem_wdata`.
  - Otherwise `ram_wbe`=0 and `ram_wdata`=0.
- Address rules:
  - Bits [2:0] are ignored for addressing.
  - Bits above RAM_AW+2 are ignored, so addresses wrap modulo RAM size.
- Handshake transitions:
  - Fetch handshake: IDLE -> RESP_IF.
  - MEM handshake: IDLE -> RESP_MEM.
- RESP_IF:
  - `if_rsp_valid`=1, `if_rsp_data`=`ram_rdata`.
  - Next state IDLE.
- RESP_MEM:
  - `mem_rsp_valid`=1.
  - `mem_rsp_data` = `ram_rdata` for a load, 0 for a store; `mem_we` is latched at handshake.
  - Next state IDLE.
- Responses cannot be back-pressured; requesters must sink them.
- `starve_cnt` (4 bits), updated in IDLE only:
  - Increments when `if_req_valid`=1 and MEM is granted.
  - Clears when fetch is granted, or in any IDLE cycle with `if_req_valid`=0.
  - Saturates at STARVE_MAX.
- Store with `mem_wstrb`=0: a RAM cycle still occurs (`ram_en`=1, `ram_wbe`=0) and is acknowledged normally.

## Timing
- Reset values: state IDLE, `starve_cnt`=0. Every output is 0: `*_req_ready`, `*_rsp_valid`, `*_rsp_data`, `ram_en`, `ram_wbe`, `ram_addr`, `ram_wdata`.
- Reset has priority over everything.
  - A transaction accepted in the cycle before `rst` produces no response.
  - No handshake fires while `rst`=1.
- Latency: handshake in cycle N, response in cycle N+1.
- Earliest next handshake is N+2, so peak throughput is one access per 2 cycles.
- Both ports valid continuously:
  - MEM is granted STARVE_MAX times, then fetch once, repeating.
  - Fetch receives one grant per STARVE_MAX+1 accesses.
- Request fields are sampled only in the handshake cycle. A requester may change or drop valid at any time; no transaction is issued without a handshake.
- All `ram_*` outputs are 0 in non-handshake cycles.

## Test plan
- Reset, then a fetch read:
  - Preload word 5 = 0x1122334455667788.
  - Set `if_addr`=0x28 with `if_req_valid`=1.
  - Required: ready in cycle 1; `ram_addr`=5; `if_rsp_valid`=1 in cycle 2 with data 0x1122334455667788.
- Byte-masked store then load:
  - Store `mem_addr`=0x40, `mem_wstrb`=0x0F, `mem_wdata`=0xAAAAAAAA_BBBBBBBB over word 8 = 0.
  - Required: `mem_rsp_valid` pulse with data 0.
  - Then load 0x40 -> `mem_rsp_data`=0x00000000_BBBBBBBB.
- Contention:
  - Both valid continuously, STARVE_MAX=4.
  - Required grant order M,M,M,M,I,M,M,M,M,I.
  - No handshake lands in a RESP_* cycle.
- Wrap-around:
  - Fetch `if_addr`=(1<<(RAM_AW+3))+0x8.
  - Required: `ram_addr`=1, and data matches word 1.
- Reset mid-operation:
  - Assert `rst` in the cycle after a MEM load handshake.
  - Required: `mem_rsp_valid` stays 0, all outputs are 0 the following cycle, and the state is IDLE.
- Starve counter clear:
  - Fetch loses 3 times, drops valid for one IDLE cycle, then both are valid.
  - Required: MEM is granted 4 more times before the fetch grant.
